// File: rtl/cache_refill_unit.sv
// Cache miss refill engine: fetches a whole block word-by-word over a req/ack
// interface and streams each word into the victim way, then strobes completion.
module cache_refill_unit #(
    parameter int ADDR_SIZE  = 32,
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 2,
    parameter int BLOCK_SIZE = 128,
    localparam int NUM_WORDS = BLOCK_SIZE / 32,
    localparam int OFF_W     = $clog2(BLOCK_SIZE / 8),
    localparam int SET_W     = $clog2(NUM_SETS),
    localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int TAG_W     = ADDR_SIZE - SET_W - OFF_W,
    localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss,
    input  logic [ADDR_SIZE-1:0] miss_addr,
    input  logic [WAY_W-1:0]     replace_way,
    output logic                 stall,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic                 fill_enable,
    output logic [WAY_W-1:0]     fill_way,
    output logic [SET_W-1:0]     fill_set,
    output logic [TAG_W-1:0]     fill_tag,
    output logic [WORD_W-1:0]    fill_word,
    output logic [31:0]          fill_data,
    output logic                 fill_done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WORD_W-1:0]  r_counter;
    logic [TAG_W-1:0]   r_tag;
    logic [SET_W-1:0]   r_set;
    logic [WAY_W-1:0]   r_way;
    logic [31:0]        r_fill_data;
    logic               r_mem_req;
    logic               r_fill_enable;
    logic               r_fill_done;
    logic               w_last;
    logic               w_mem_req_next;
    logic               w_fill_enable_next;
    logic               w_fill_done_next;
    logic [ADDR_SIZE-1:0] w_base;

    assign w_last = (r_counter == WORD_W'(NUM_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (miss) w_state_next = S_FETCH;
            S_FETCH: if (mem_ack) w_state_next = S_WRITE;
            S_WRITE: w_state_next = w_last ? S_DONE : S_FETCH;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the upcoming state.
    always_comb begin
        w_mem_req_next     = (w_state_next == S_FETCH);
        w_fill_enable_next = (w_state_next == S_WRITE);
        w_fill_done_next   = (w_state_next == S_DONE);
        stall              = 1'b0;
        if (!rst) begin
            stall = (r_state == S_IDLE) ? miss : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter     <= '0;
            r_tag         <= '0;
            r_set         <= '0;
            r_way         <= '0;
            r_fill_data   <= '0;
            r_mem_req     <= 1'b0;
            r_fill_enable <= 1'b0;
            r_fill_done   <= 1'b0;
        end else begin
            r_mem_req     <= w_mem_req_next;
            r_fill_enable <= w_fill_enable_next;
            r_fill_done   <= w_fill_done_next;
            if (r_state == S_IDLE && miss) begin
                r_tag     <= miss_addr[ADDR_SIZE-1 -: TAG_W];
                r_set     <= miss_addr[OFF_W +: SET_W];
                r_way     <= replace_way;
                r_counter <= '0;
            end
            if (r_state == S_FETCH && mem_ack) begin
                r_fill_data <= mem_rdata;
            end
            if (r_state == S_WRITE && !w_last) begin
                r_counter <= r_counter + 1'b1;
            end
        end
    end

    // Word offset is OR-ed into a block-aligned base, so it can never carry into set/tag.
    assign w_base      = {r_tag, r_set, {OFF_W{1'b0}}};
    assign mem_addr    = w_base | (ADDR_SIZE'(r_counter) << 2);
    assign mem_req     = r_mem_req;
    assign fill_enable = r_fill_enable;
    assign fill_way    = r_way;
    assign fill_set    = r_set;
    assign fill_tag    = r_tag;
    assign fill_word   = r_counter;
    assign fill_data   = r_fill_data;
    assign fill_done   = r_fill_done;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Randomised refill bench: a transaction-level model predicts beat addresses,
// fill writes and stall length, for a 4-word and a 1-word block instance.
module tb_cache_refill_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss;
    logic [31:0] miss_addr;
    logic [0:0]  replace_way;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        a_stall, a_mem_req, a_fill_enable, a_fill_done;
    logic [31:0] a_mem_addr, a_fill_data;
    logic [0:0]  a_fill_way;
    logic [3:0]  a_fill_set;
    logic [23:0] a_fill_tag;
    logic [1:0]  a_fill_word;

    logic        b_stall, b_mem_req, b_fill_enable, b_fill_done;
    logic [31:0] b_mem_addr, b_fill_data;
    logic [0:0]  b_fill_way;
    logic [3:0]  b_fill_set;
    logic [25:0] b_fill_tag;
    logic [0:0]  b_fill_word;

    logic        sel;
    logic        ob_stall, ob_mem_req, ob_fill_enable, ob_done;
    logic [31:0] ob_mem_addr, ob_way, ob_set, ob_tag, ob_word, ob_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_refill_unit u_dut4 (
        .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr), .replace_way(replace_way),
        .stall(a_stall), .mem_req(a_mem_req), .mem_addr(a_mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .fill_enable(a_fill_enable), .fill_way(a_fill_way),
        .fill_set(a_fill_set), .fill_tag(a_fill_tag), .fill_word(a_fill_word),
        .fill_data(a_fill_data), .fill_done(a_fill_done)
    );

    cache_refill_unit #(.BLOCK_SIZE(32)) u_dut1 (
        .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr), .replace_way(replace_way),
        .stall(b_stall), .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .fill_enable(b_fill_enable), .fill_way(b_fill_way),
        .fill_set(b_fill_set), .fill_tag(b_fill_tag), .fill_word(b_fill_word),
        .fill_data(b_fill_data), .fill_done(b_fill_done)
    );

    always_comb begin
        if (sel) begin
            ob_stall = b_stall; ob_mem_req = b_mem_req; ob_mem_addr = b_mem_addr;
            ob_fill_enable = b_fill_enable; ob_done = b_fill_done; ob_data = b_fill_data;
            ob_way = 32'(b_fill_way); ob_set = 32'(b_fill_set);
            ob_tag = 32'(b_fill_tag); ob_word = 32'(b_fill_word);
        end else begin
            ob_stall = a_stall; ob_mem_req = a_mem_req; ob_mem_addr = a_mem_addr;
            ob_fill_enable = a_fill_enable; ob_done = a_fill_done; ob_data = a_fill_data;
            ob_way = 32'(a_fill_way); ob_set = 32'(a_fill_set);
            ob_tag = 32'(a_fill_tag); ob_word = 32'(a_fill_word);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete miss transaction. Waits per beat are drawn from [minw,maxw];
    // abort_after>0 asserts rst in the cycle after that many fill writes.
    task automatic refill(input logic [31:0] addr, input logic way, input int minw,
                          input int maxw, input bit spurious, input int abort_after);
        int nw, offw, beats, writes, dones, stall_cyc, waitsum, w, cnt;
        bit aborted, abort_pend, finished;
        logic [31:0] base, eset, etag;
        logic [31:0] rq[$];
        nw   = sel ? 1 : 4;
        offw = sel ? 2 : 4;
        base = addr & ~((32'd1 << offw) - 32'd1);
        eset = (addr >> offw) & 32'hF;
        etag = addr >> (offw + 4);
        beats = 0; writes = 0; dones = 0; stall_cyc = 0; waitsum = 0; cnt = 0;
        aborted = 0; abort_pend = 0; finished = 0;
        w = $urandom_range(maxw, minw);

        @(posedge clk); #1;
        miss = 1'b1; miss_addr = addr; replace_way = way;
        @(negedge clk);
        check_eq("stall_on_miss", 32'(ob_stall), 32'd1);
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            mem_ack = 1'b0; miss = 1'b0; mem_rdata = $urandom;
            if (rst) begin
                rst = 1'b0; aborted = 1;
            end else if (abort_pend) begin
                rst = 1'b1;
            end else if (ob_mem_req) begin
                if (cnt == w) begin
                    mem_ack = 1'b1; rq.push_back(mem_rdata); waitsum += w;
                    cnt = 0; w = $urandom_range(maxw, minw);
                end else begin
                    cnt++;
                end
                if (spurious) begin miss = 1'b1; miss_addr = addr ^ 32'h5550; end
            end else if (spurious && (ob_fill_enable || ob_done)) begin
                mem_ack = 1'b1; miss = 1'b1; miss_addr = addr ^ 32'h0AA0;
            end
            @(negedge clk);
            if (aborted) begin
                check_eq("abort_stall", 32'(ob_stall), 32'd0);
                check_eq("abort_mem_req", 32'(ob_mem_req), 32'd0);
                check_eq("abort_fill_en", 32'(ob_fill_enable), 32'd0);
                check_eq("abort_no_done", 32'(dones), 32'd0);
                finished = 1;
                break;
            end
            if (rst) begin
                check_eq("stall_in_rst", 32'(ob_stall), 32'd0);
            end else begin
                if (ob_stall) stall_cyc++;
                if (ob_mem_req) check_eq("mem_addr", ob_mem_addr, base + 32'(4 * beats));
                if (ob_mem_req && mem_ack) beats++;
                if (ob_fill_enable) begin
                    check_eq("fill_in_order", 32'(writes < rq.size()), 32'd1);
                    if (writes < rq.size()) check_eq("fill_data", ob_data, rq[writes]);
                    check_eq("fill_word", ob_word, 32'(writes));
                    check_eq("fill_way", ob_way, 32'(way));
                    check_eq("fill_set", ob_set, eset);
                    check_eq("fill_tag", ob_tag, etag);
                    writes++;
                    if (writes == abort_after) abort_pend = 1;
                end
                if (ob_done) begin
                    dones++;
                    check_eq("done_cycle", 32'(cyc), 32'(2 * nw + 1 + waitsum));
                end
                if (!ob_stall) begin finished = 1; break; end
            end
            @(posedge clk); #1;
        end
        check_eq("refill_terminated", 32'(finished), 32'd1);
        if (!aborted) begin
            check_eq("stall_cycles", 32'(stall_cyc), 32'(2 * nw + 1 + waitsum));
            check_eq("beats", 32'(beats), 32'(nw));
            check_eq("fill_writes", 32'(writes), 32'(nw));
            check_eq("fill_done_count", 32'(dones), 32'd1);
        end
        mem_ack = 1'b0; miss = 1'b0;
        $display("refill addr=0x%08h way=%0d words=%0d waits=%0d stall=%0d writes=%0d done=%0d aborted=%0d",
                 addr, way, nw, waitsum, stall_cyc, writes, dones, aborted);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1; miss = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1; miss = 1'b1; mem_ack = 1'b1; miss_addr = 32'h0000_1234;
        replace_way = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_stall4", 32'(a_stall), 32'd0);
            check_eq("rst_req4", 32'(a_mem_req), 32'd0);
            check_eq("rst_fill_en4", 32'(a_fill_enable), 32'd0);
            check_eq("rst_done4", 32'(a_fill_done), 32'd0);
            check_eq("rst_stall1", 32'(b_stall), 32'd0);
            check_eq("rst_req1", 32'(b_mem_req), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; miss = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        check_eq("post_rst_addr", a_mem_addr, 32'd0);
        check_eq("post_rst_data", a_fill_data, 32'd0);
        check_eq("post_rst_tag", 32'(a_fill_tag), 32'd0);
        check_eq("post_rst_word", 32'(a_fill_word), 32'd0);
        check_eq("post_rst_stall", 32'(a_stall), 32'd0);

        refill(32'h0000_1234, 1'b1, 0, 0, 1'b0, 0);
        refill(32'h0000_ABC8, 1'b0, 3, 3, 1'b0, 0);
        refill(32'h0000_1234, 1'b0, 0, 1, 1'b1, 0);
        refill(32'h0000_2468, 1'b1, 0, 0, 1'b0, 2);
        refill(32'h0000_2468, 1'b1, 0, 0, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            refill($urandom, 1'($urandom), 0, 2, 1'($urandom), 0);
        end

        pulse_reset();
        sel = 1'b1;
        refill(32'h0000_0040, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            refill($urandom, 1'($urandom), 0, 2, 1'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
